// File: rtl/qpd_sumdiff_stream.sv
// qpd_sumdiff_stream: snapshots NPAIR QPD channel pairs per tick and streams scaled, saturated sum/diff per pair
module qpd_sumdiff_stream #(
   parameter int W = 24,
   parameter int NPAIR = 2,
   parameter int INVERT = 1,
   parameter int CNTW = 32,
   localparam int PW = (NPAIR > 1) ? $clog2(NPAIR) : 1
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    tick_i,
   input  logic [2*NPAIR*W-1:0]    data_i,
   output logic [W-1:0]            sum_o,
   output logic [W-1:0]            diff_o,
   output logic [PW-1:0]           pair_o,
   output logic                    valid_o,
   input  logic                    ready_i,
   output logic                    frame_done_o,
   output logic [CNTW-1:0]         count_o,
   output logic                    overrun_o
);
   typedef enum logic [1:0] {IDLE, LOAD, EMIT} state_t;
   state_t state, state_nx;
   logic [2*NPAIR*W-1:0] snap;
   logic acc, last, capture, advance;
   logic [PW-1:0] sel;
   logic signed [W-1:0] a, b;
   logic signed [W+1:0] s_x, d_x;

   // Optional negation, halving, then clamp; the top three bits agree exactly when the value fits in W bits.
   function automatic logic [W-1:0] scale(input logic signed [W+1:0] x);
      logic signed [W+1:0] n, h;
      n = (INVERT != 0) ? -x : x;
      h = n >>> 1;
      return (h[W+1:W-1] == 3'b000 || h[W+1:W-1] == 3'b111) ? h[W-1:0] : {h[W+1], {(W-1){~h[W+1]}}};
   endfunction

   // Handshake decode, next state and selection of the pair to present next.
   always_comb begin
      acc = state == EMIT && ready_i;
      last = acc && pair_o == PW'(NPAIR - 1);
      capture = tick_i && (state == IDLE || last);
      advance = state == LOAD || (acc && !last);
      sel = (state == LOAD) ? '0 : pair_o + 1'b1;
      state_nx = capture ? LOAD : (state == LOAD) ? EMIT : last ? IDLE : state;
      a = '0;
      b = '0;
      for (int p = 0; p < NPAIR; p++)
         if (sel == PW'(p)) begin
            a = snap[2*p*W +: W];
            b = snap[(2*p+1)*W +: W];
         end
      s_x = {{2{a[W-1]}}, a} + {{2{b[W-1]}}, b};
      d_x = {{2{a[W-1]}}, a} - {{2{b[W-1]}}, b};
   end

   // State register.
   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) state <= IDLE;
      else state <= state_nx;

   // Snapshot capture on accepted ticks; any other tick while busy is dropped and flagged.
   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) begin
         snap <= '0;
         overrun_o <= 1'b0;
      end else begin
         if (capture) snap <= data_i;
         if (tick_i && state != IDLE && !capture) overrun_o <= 1'b1;
      end

   // Beat register: load a new pair on LOAD or non-final accept, close the frame on final accept.
   always_ff @(posedge clk_i or posedge reset_i)
      if (reset_i) begin
         sum_o <= '0;
         diff_o <= '0;
         pair_o <= '0;
         valid_o <= 1'b0;
         frame_done_o <= 1'b0;
         count_o <= '0;
      end else begin
         frame_done_o <= 1'b0;
         if (advance) begin
            sum_o <= scale(s_x);
            diff_o <= scale(d_x);
            pair_o <= sel;
            valid_o <= 1'b1;
         end else if (last) begin
            valid_o <= 1'b0;
            frame_done_o <= 1'b1;
            count_o <= count_o + 1'b1;
         end
      end
endmodule

// File: tb/tb_qpd_sumdiff_stream.sv
// tb_qpd_sumdiff_stream: directed vector bench for inverting/non-inverting sum/diff streaming
module tb_qpd_sumdiff_stream;
   typedef struct packed {
      logic [3:0][23:0] ch;
      logic [3:0][23:0] ei;
      logic [3:0][23:0] en;
   } vec_t;

   logic clk, reset_i, tick, ready;
   logic [95:0] data;
   logic signed [23:0] sum_a, diff_a, sum_b, diff_b;
   logic [0:0] pair_a, pair_b;
   logic valid_a, valid_b, done_a, done_b, ovr_a, ovr_b;
   logic [3:0] cnt_a;
   logic [31:0] cnt_b;
   int checks = 0, errors = 0;
   int exp_cnt = 0;
   vec_t vt[5];

   qpd_sumdiff_stream #(.W(24), .NPAIR(2), .INVERT(1), .CNTW(4)) dut_a (
      .clk_i(clk), .reset_i(reset_i), .tick_i(tick), .data_i(data),
      .sum_o(sum_a), .diff_o(diff_a), .pair_o(pair_a), .valid_o(valid_a), .ready_i(ready),
      .frame_done_o(done_a), .count_o(cnt_a), .overrun_o(ovr_a));

   qpd_sumdiff_stream #(.W(24), .NPAIR(2), .INVERT(0), .CNTW(32)) dut_b (
      .clk_i(clk), .reset_i(reset_i), .tick_i(tick), .data_i(data),
      .sum_o(sum_b), .diff_o(diff_b), .pair_o(pair_b), .valid_o(valid_b), .ready_i(ready),
      .frame_done_o(done_b), .count_o(cnt_b), .overrun_o(ovr_b));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic set_vec(input int i, input int c0, c1, c2, c3,
                          input int is0, id0, is1, id1, input int ns0, nd0, ns1, nd1);
      vt[i].ch = {24'(c3), 24'(c2), 24'(c1), 24'(c0)};
      vt[i].ei = {24'(id1), 24'(is1), 24'(id0), 24'(is0)};
      vt[i].en = {24'(nd1), 24'(ns1), 24'(nd0), 24'(ns0)};
   endtask

   task automatic chk_beat(input string tag, input vec_t v, input int p);
      chk({tag, " valid_a"}, valid_a, 1);
      chk({tag, " valid_b"}, valid_b, 1);
      chk({tag, " pair_a"}, pair_a, p);
      chk({tag, " pair_b"}, pair_b, p);
      chk({tag, " sum_a"}, $signed(v.ei[2*p]), $signed(v.ei[2*p]) == sum_a ? $signed(v.ei[2*p]) : $signed(v.ei[2*p]));
      chk({tag, " sum_a"}, sum_a, $signed(v.ei[2*p]));
      chk({tag, " diff_a"}, diff_a, $signed(v.ei[2*p+1]));
      chk({tag, " sum_b"}, sum_b, $signed(v.en[2*p]));
      chk({tag, " diff_b"}, diff_b, $signed(v.en[2*p+1]));
      chk({tag, " done_a"}, done_a, 0);
   endtask

   task automatic chk_end(input string tag);
      exp_cnt++;
      chk({tag, " end valid_a"}, valid_a, 0);
      chk({tag, " end valid_b"}, valid_b, 0);
      chk({tag, " done_a"}, done_a, 1);
      chk({tag, " done_b"}, done_b, 1);
      chk({tag, " count_a"}, cnt_a, exp_cnt % 16);
      chk({tag, " count_b"}, cnt_b, exp_cnt);
   endtask

   task automatic run_frame(input string tag, input vec_t v);
      data = v.ch;
      tick = 1'b1;
      step;
      tick = 1'b0;
      chk({tag, " latency valid"}, valid_a, 0);
      step;
      chk_beat({tag, " b0"}, v, 0);
      step;
      chk_beat({tag, " b1"}, v, 1);
      step;
      chk_end(tag);
   endtask

   initial begin
      set_vec(0, 1000, 600, -200, -400, -800, -200, 300, -100, 800, 200, -300, 100);
      set_vec(1, -8388608, -8388608, -8388608, 8388607, 8388607, 0, 0, 8388607, -8388608, 0, -1, -8388608);
      set_vec(2, 3, 0, -3, 0, -2, -2, 1, 1, 1, 1, -2, -2);
      set_vec(3, 8388607, 8388607, 0, -1, -8388607, 0, 0, -1, 8388607, 0, -1, 0);
      set_vec(4, -5, 7, 100, -50, -1, 6, -25, -75, 1, -6, 25, 75);
      reset_i = 1'b0;
      tick = 1'b0;
      ready = 1'b1;
      data = '0;
      #3 reset_i = 1'b1;
      step;
      reset_i = 1'b0;
      step;
      chk("rst sum", sum_a, 0);
      chk("rst diff", diff_a, 0);
      chk("rst pair", pair_a, 0);
      chk("rst valid", valid_a, 0);
      chk("rst done", done_a, 0);
      chk("rst count", cnt_b, 0);
      chk("rst overrun", ovr_a, 0);
      for (int i = 0; i < 5; i++) run_frame($sformatf("vec%0d", i), vt[i]);
      // Stall on beat 0 with changing data: outputs hold and the snapshot is unaffected.
      data = vt[0].ch;
      tick = 1'b1;
      ready = 1'b0;
      step;
      tick = 1'b0;
      step;
      chk_beat("stall b0", vt[0], 0);
      for (int i = 0; i < 5; i++) begin
         data = {$urandom, $urandom, $urandom};
         step;
         chk_beat($sformatf("stall hold%0d", i), vt[0], 0);
      end
      ready = 1'b1;
      step;
      chk_beat("stall b1", vt[0], 1);
      step;
      chk_end("stall");
      // Tick on the final-accept cycle chains straight into a new frame without overrun.
      data = vt[2].ch;
      tick = 1'b1;
      step;
      tick = 1'b0;
      step;
      chk_beat("chain b0", vt[2], 0);
      step;
      chk_beat("chain b1", vt[2], 1);
      data = vt[4].ch;
      tick = 1'b1;
      step;
      tick = 1'b0;
      chk_end("chain");
      step;
      chk_beat("chain2 b0", vt[4], 0);
      chk("chain overrun", ovr_a, 0);
      step;
      chk_beat("chain2 b1", vt[4], 1);
      step;
      chk_end("chain2");
      chk("chain2 overrun", ovr_b, 0);
      // Tick during beat 0 is dropped and sets the sticky overrun flag.
      data = vt[0].ch;
      tick = 1'b1;
      step;
      tick = 1'b0;
      step;
      chk_beat("ovr b0", vt[0], 0);
      data = vt[1].ch;
      tick = 1'b1;
      step;
      tick = 1'b0;
      chk("ovr set", ovr_a, 1);
      chk_beat("ovr b1", vt[0], 1);
      step;
      chk_end("ovr");
      step;
      chk("ovr dropped valid", valid_a, 0);
      chk("ovr sticky", ovr_a, 1);
      // Asynchronous reset mid-frame while stalled on pair 1.
      data = vt[1].ch;
      tick = 1'b1;
      step;
      tick = 1'b0;
      step;
      step;
      ready = 1'b0;
      step;
      chk_beat("mid b1", vt[1], 1);
      #2 reset_i = 1'b1;
      #1;
      chk("async sum", sum_a, 0);
      chk("async diff", diff_b, 0);
      chk("async pair", pair_a, 0);
      chk("async valid", valid_a, 0);
      chk("async done", done_a, 0);
      chk("async count", cnt_b, 0);
      chk("async overrun", ovr_a, 0);
      step;
      reset_i = 1'b0;
      ready = 1'b1;
      exp_cnt = 0;
      step;
      chk("post rst done", done_a, 0);
      chk("post rst valid", valid_a, 0);
      chk("post rst count", cnt_a, 0);
      // Walk the 4-bit counter to its maximum, then one more frame wraps it.
      for (int i = 0; i < 15; i++) run_frame($sformatf("cnt%0d", i), vt[i % 5]);
      chk("count max", cnt_a, 15);
      run_frame("wrap", vt[3]);
      chk("count wrap", cnt_a, 0);
      chk("count wide", cnt_b, 16);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
